// File: rtl/gcd_arbiter_if.sv
// gcd_arbiter_if: request/response bundle between two requesters, the result
// consumer and gcd_arbiter. The iter_count signal only exists when
// GCD_ITER_CNT_EN is defined.
interface gcd_arbiter_if #(
  parameter int W = 8
);
  logic [1:0]   req_valid;
  logic [W-1:0] req_a0;
  logic [W-1:0] req_b0;
  logic [W-1:0] req_a1;
  logic [W-1:0] req_b1;
  logic [1:0]   req_ready;
  logic         resp_valid;
  logic         resp_id;
  logic [W-1:0] resp_gcd;
  logic         resp_ready;
  logic         busy;
`ifdef GCD_ITER_CNT_EN
  logic [15:0]  iter_count;
`endif

`ifdef GCD_ITER_CNT_EN
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_gcd, busy, iter_count
  );
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_gcd, busy, iter_count
  );
`else
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_gcd, busy
  );
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_gcd, busy
  );
`endif
endinterface

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: two-requester round-robin arbiter in front of a single
// subtract/swap GCD engine (IDLE -> RUN -> DONE).
// Optional feature macro: GCD_ITER_CNT_EN adds a 16-bit saturating count of
// subtract+swap actions for the current job on bus.iter_count.
module gcd_arbiter #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          reset,
  gcd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic [W-1:0] x_q;
  logic [W-1:0] y_q;
  logic         owner_q;
  logic         rr_q;
  logic         resp_valid_q;
  logic         resp_id_q;
  logic [W-1:0] resp_gcd_q;
  logic         busy_q;

  logic         any_req;
  logic         grant;
  logic [1:0]   req_ready_d;
  logic         do_step;

  // Arbitration: round-robin pointer breaks ties, otherwise the lone requester wins
  always_comb begin
    any_req = |bus.req_valid;
    grant   = 1'b0;
    if (bus.req_valid == 2'b11) begin
      grant = rr_q;
    end else begin
      grant = bus.req_valid[1];
    end
  end

  // Acceptance pulse is decoded from IDLE so it lines up with the capture edge
  always_comb begin
    req_ready_d = '0;
    if ((state_q == IDLE) && any_req) begin
      req_ready_d = grant ? 2'b10 : 2'b01;
    end
  end

  assign do_step = (state_q == RUN) && (y_q != '0);

  // Main FSM: capture, subtract/swap iteration, and result hold until handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_gcd_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            x_q     <= grant ? bus.req_a1 : bus.req_a0;
            y_q     <= grant ? bus.req_b1 : bus.req_b0;
            owner_q <= grant;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (y_q == '0) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= owner_q;
            resp_gcd_q   <= x_q;
            state_q      <= DONE;
          end else if (x_q >= y_q) begin
            x_q <= x_q - y_q;
          end else begin
            x_q <= y_q;
            y_q <= x_q;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_gcd_q   <= '0;
            busy_q       <= 1'b0;
            rr_q         <= ~owner_q;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef GCD_ITER_CNT_EN
  logic [15:0] iter_q;

  // Per-job action counter: cleared at grant, saturating, frozen outside RUN steps
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_q <= '0;
    end else if ((state_q == IDLE) && any_req) begin
      iter_q <= '0;
    end else if (do_step && (iter_q != '1)) begin
      iter_q <= iter_q + 16'd1;
    end
  end

  assign bus.iter_count = iter_q;
`else
  logic unused_step;
  assign unused_step = do_step;
`endif

  assign bus.req_ready  = req_ready_d;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_gcd   = resp_gcd_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: cycle-level reference of the arbiter/GCD job flow with
// directed scenarios and randomized traffic. Build with +define+GCD_ITER_CNT_EN
// to also check iter_count.
module tb_gcd_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.W(W)) bus ();
  gcd_arbiter #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } job_t;

  job_t q0[$];
  job_t q1[$];
  int   obs_grants[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference state: 0 idle, 1 computing, 2 result presented
  int m_phase, m_run_left, m_owner, m_rr, m_gcd, m_iter;
  int hold0, hold1, stall_left, policy, jobs_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // number of subtract/swap actions taken by the subtract-or-swap rule
  function automatic int ref_iters(input int a, input int b);
    int n, t;
    n = 0;
    while (b != 0) begin
      if (a >= b) a = a - b;
      else begin t = a; a = b; b = t; end
      n++;
    end
    return (n > 65535) ? 65535 : n;
  endfunction

  task automatic push(input int r, input int a, input int b);
    job_t j;
    j.a = a[W-1:0];
    j.b = b[W-1:0];
    if (r == 0) q0.push_back(j); else q1.push_back(j);
  endtask

  task automatic model_reset();
    m_phase = 0; m_run_left = 0; m_owner = 0; m_rr = 0;
    m_gcd = 0; m_iter = 0; stall_left = 0;
  endtask

  task automatic tick();
    logic [1:0] pend, exp_rdy;
    job_t j;
    int g;
    @(posedge clk); #1;
    if (hold0 > 0) hold0--;
    if (hold1 > 0) hold1--;
    pend[0] = (q0.size() > 0) && (hold0 == 0);
    pend[1] = (q1.size() > 0) && (hold1 == 0);
    bus.req_valid = pend;
    bus.req_a0 = pend[0] ? q0[0].a : W'($urandom);
    bus.req_b0 = pend[0] ? q0[0].b : W'($urandom);
    bus.req_a1 = pend[1] ? q1[0].a : W'($urandom);
    bus.req_b1 = pend[1] ? q1[0].b : W'($urandom);
    case (policy)
      1: bus.resp_ready = 1'($urandom_range(0, 1));
      2: begin
        if (m_phase == 2 && stall_left > 0) begin
          bus.resp_ready = 1'b0;
          stall_left--;
        end else bus.resp_ready = 1'b1;
      end
      default: bus.resp_ready = 1'b1;
    endcase

    @(negedge clk);
    check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
    case (m_phase)
      0: begin
        if (pend == 2'b11) exp_rdy = (m_rr != 0) ? 2'b10 : 2'b01;
        else exp_rdy = pend;
        check("req_ready", bus.req_ready, exp_rdy);
        check("busy_idle", bus.busy, 0);
        check("resp_valid_idle", bus.resp_valid, 0);
        if (bus.req_ready != 2'b00) obs_grants.push_back(bus.req_ready[1] ? 1 : 0);
        if (exp_rdy != 2'b00) begin
          g = exp_rdy[1] ? 1 : 0;
          if (g == 0) begin j = q0.pop_front(); hold0 = (policy == 1) ? $urandom_range(0, 3) : 0; end
          else begin j = q1.pop_front(); hold1 = (policy == 1) ? $urandom_range(0, 3) : 0; end
          m_owner    = g;
          m_gcd      = ref_gcd(int'(j.a), int'(j.b));
          m_iter     = ref_iters(int'(j.a), int'(j.b));
          m_run_left = ref_iters(int'(j.a), int'(j.b)) + 1;
          m_phase    = 1;
          stall_left = (policy == 2) ? 5 : 0;
        end
      end
      1: begin
        check("busy_run", bus.busy, 1);
        check("req_ready_run", bus.req_ready, 0);
        check("resp_valid_run", bus.resp_valid, 0);
        m_run_left--;
        if (m_run_left == 0) m_phase = 2;
      end
      default: begin
        check("resp_valid", bus.resp_valid, 1);
        check("resp_id", bus.resp_id, m_owner);
        check("resp_gcd", bus.resp_gcd, m_gcd);
        check("busy_done", bus.busy, 1);
        check("req_ready_done", bus.req_ready, 0);
`ifdef GCD_ITER_CNT_EN
        check("iter_count", bus.iter_count, m_iter);
`endif
        if (bus.resp_ready) begin
          m_rr = 1 - m_owner;
          m_phase = 0;
          jobs_done++;
        end
      end
    endcase
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((m_phase != 0 || q0.size() > 0 || q1.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.resp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_id", bus.resp_id, 0);
    check("rst_resp_gcd", bus.resp_gcd, 0);
    check("rst_busy", bus.busy, 0);
`ifdef GCD_ITER_CNT_EN
    check("rst_iter", bus.iter_count, 0);
`endif
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int r, a, b;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    bus.resp_ready = 1'b0;
    hold0 = 0; hold1 = 0; policy = 0; jobs_done = 0;
    model_reset();
    do_reset();

    // contention from reset, then requester 0 re-requests
    push(0, 12, 8); push(1, 35, 21); push(0, 20, 6);
    run_until_idle(500);
    check("rr_count", obs_grants.size(), 3);
    if (obs_grants.size() == 3) begin
      check("rr_first", obs_grants[0], 0);
      check("rr_second", obs_grants[1], 1);
      check("rr_third", obs_grants[2], 0);
    end

    push(0, 48, 18);
    run_until_idle(500);

    push(0, 0, 0); push(0, 13, 0); push(1, 0, 9);
    run_until_idle(500);

    // consumer stalls five cycles in DONE
    policy = 2;
    push(1, 48, 18);
    run_until_idle(500);
    policy = 0;

    // long job on requester 1 while requester 0 waits
    push(1, 255, 1);
    tick();
    push(0, 5, 5);
    run_until_idle(1000);

    // reset during the third RUN cycle discards the job
    push(0, 48, 18);
    repeat (4) tick();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_phase_run", m_phase, 1);
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_resp_gcd", bus.resp_gcd, 0);
    check("midrst_resp_id", bus.resp_id, 0);
    check("midrst_req_ready", bus.req_ready, 0);
`ifdef GCD_ITER_CNT_EN
    check("midrst_iter", bus.iter_count, 0);
`endif
    reset = 1'b0;
    model_reset();
    repeat (3) tick();
    push(0, 48, 18);
    run_until_idle(500);

    // randomized traffic with random consumer back-pressure
    policy = 1;
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 1);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) a = 0;
      if ($urandom_range(0, 7) == 0) b = 0;
      push(r, a, b);
      if ($urandom_range(0, 2) == 0) run_until_idle(2000);
      else tick();
    end
    run_until_idle(40000);
    repeat (3) tick();
    check("jobs_done", jobs_done, 131);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
